// File: rtl/mc_controller.sv
// mc_controller: multi-cycle MIPS control unit.
//   Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
//   shared datapath from the current state plus the IR op/func fields.
//   Data memory accesses wait for mem_ready. A wait that runs too long ends
//   in a sticky FAULT state, which only reset clears.
//
// Parameters
//   MEM_TIMEOUT  longest MEM wait in cycles; 0 means wait indefinitely
//   ZERO_WAIT    1: every MEM state lasts one cycle and mem_ready is ignored
//
// Ports
//   clk, reset        clock (rising edge); asynchronous active-high reset
//   op, func          IR[31:26], IR[5:0]
//   zero              ALU equal flag, valid in EXEC
//   mem_ready         data memory has finished the current access
//   IRWrite, PCWrite  IR latch and PC update strobes
//   MemRead/MemWrite  data memory strobes
//   MemtoReg, RegDst  GRF write data / address selects
//   RegWrite          GRF write enable
//   ALU_SRC, ALUop    ALU B select and operation
//   NPCop, EXTop      next-PC select and immediate extension mode
//   state, fault      debug state encoding; sticky fault flag
//
// state  | meaning
// FETCH  | read instruction into IR, PC <= PC+4
// DECODE | decode; jumps (j/jal/jr) and nop finish here
// EXEC   | ALU operation; beq resolves here
// MEM    | data memory access; waits for mem_ready, bounded by MEM_TIMEOUT
// WB     | write result to the GRF
// FAULT  | unsupported instruction or memory timeout; absorbing until reset
module mc_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter bit ZERO_WAIT   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic [1:0] MemtoReg,
  output logic       ALU_SRC,
  output logic [1:0] RegDst,
  output logic       RegWrite,
  output logic [3:0] ALUop,
  output logic [1:0] NPCop,
  output logic       EXTop,
  output logic [2:0] state,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_t;

  // The counter must still be at least one bit wide when the timeout is disabled.
  localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_LAST = CW'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Instruction decode
  logic is_r, is_addu, is_subu, is_jr, is_nop;
  logic is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal, is_known;

  assign is_r     = (op == 6'h00);
  assign is_addu  = is_r && (func == 6'h21);
  assign is_subu  = is_r && (func == 6'h23);
  assign is_jr    = is_r && (func == 6'h08);
  assign is_nop   = is_r && (func == 6'h00);
  assign is_ori   = (op == 6'h0D);
  assign is_lui   = (op == 6'h0F);
  assign is_lw    = (op == 6'h23);
  assign is_sw    = (op == 6'h2B);
  assign is_beq   = (op == 6'h04);
  assign is_j     = (op == 6'h02);
  assign is_jal   = (op == 6'h03);
  assign is_known = is_addu | is_subu | is_jr | is_nop | is_ori | is_lui |
                    is_lw | is_sw | is_beq | is_j | is_jal;

  // The mux selects follow the current decode in every state.
  logic [3:0] dec_alu;
  logic [1:0] dec_m2r, dec_rd, dec_npc;
  logic       dec_src, dec_ext;

  assign dec_alu = is_lui ? 4'd3 : is_ori ? 4'd2 : (is_subu | is_beq) ? 4'd1 : 4'd0;
  assign dec_src = is_ori | is_lui | is_lw | is_sw;
  assign dec_ext = is_lw | is_sw | is_beq;
  assign dec_rd  = is_jal ? 2'd2 : (is_addu | is_subu) ? 2'd1 : 2'd0;
  assign dec_m2r = is_jal ? 2'd2 : is_lw ? 2'd1 : 2'd0;
  assign dec_npc = is_beq ? 2'd1 : (is_j | is_jal) ? 2'd2 : is_jr ? 2'd3 : 2'd0;

  logic ready_eff;
  assign ready_eff = ZERO_WAIT ? 1'b1 : mem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    MemtoReg = dec_m2r;
    ALU_SRC  = dec_src;
    RegDst   = dec_rd;
    ALUop    = dec_alu;
    NPCop    = dec_npc;
    EXTop    = dec_ext;

    case (state_q)
      S_FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        NPCop   = 2'd0;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_j || is_jal || is_jr) begin
          PCWrite  = 1'b1;
          RegWrite = is_jal;
          state_d  = S_FETCH;
        end else if (is_nop) begin
          state_d = S_FETCH;
        end else if (!is_known) begin
          state_d = S_FAULT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_lw || is_sw) begin
          cnt_d   = '0;
          state_d = S_MEM;
        end else if (is_beq) begin
          PCWrite = zero;
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        MemRead  = is_lw;
        MemWrite = is_sw;
        if (ready_eff) begin
          state_d = is_lw ? S_WB : S_FETCH;
        end else if ((MEM_TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d = S_FAULT;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase

    // Reset is asynchronous, so all outputs drop in the same cycle reset is asserted.
    if (reset) begin
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      MemtoReg = 2'd0;
      ALU_SRC  = 1'b0;
      RegDst   = 2'd0;
      ALUop    = 4'd0;
      NPCop    = 2'd0;
      EXTop    = 1'b0;
    end
  end

  assign state = state_q;
  assign fault = !reset && (state_q == S_FAULT);

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, func;
  logic       zero, mem_ready;
  logic       IRWrite, PCWrite, MemRead, MemWrite, ALU_SRC, RegWrite, EXTop, fault;
  logic [1:0] MemtoReg, RegDst, NPCop;
  logic [3:0] ALUop;
  logic [2:0] state;
  logic [16:0] outs;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mc_controller #(.MEM_TIMEOUT(15), .ZERO_WAIT(1'b0)) dut (
    .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .ALU_SRC(ALU_SRC), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUop(ALUop), .NPCop(NPCop), .EXTop(EXTop), .state(state), .fault(fault)
  );

  assign outs = {IRWrite, PCWrite, MemRead, MemWrite, MemtoReg, ALU_SRC,
                 RegDst, RegWrite, ALUop, NPCop, EXTop};

  function automatic logic [16:0] f(input logic ir, input logic pc, input logic mr,
                                    input logic mw, input logic [1:0] m2r, input logic src,
                                    input logic [1:0] rd, input logic rw, input logic [3:0] alu,
                                    input logic [1:0] npc, input logic ext);
    return {ir, pc, mr, mw, m2r, src, rd, rw, alu, npc, ext};
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Check the current cycle's state and outputs, then advance one clock.
  task automatic cyc(input string tag, input logic [2:0] st, input logic [16:0] v);
    #1;
    check({tag, "_state"}, 32'(state), 32'(st));
    check({tag, "_outs"},  32'(outs),  32'(v));
    check({tag, "_fault"}, 32'(fault), 32'(st == 3'd7));
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    #1;
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_outs"},  32'(outs),  32'd0);
    check({tag, "_fault"}, 32'(fault), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  localparam logic [16:0] LW_SEL  = 17'b0_0_0_0_01_1_00_0_0000_00_1;
  localparam logic [16:0] SW_SEL  = 17'b0_0_0_0_00_1_00_0_0000_00_1;
  localparam logic [16:0] BEQ_SEL = 17'b0_0_0_0_00_0_00_0_0001_01_1;

  initial begin
    reset = 1'b1; op = 6'h23; func = 6'h00; zero = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rst_state", 32'(state), 32'd0);
      check("rst_outs",  32'(outs),  32'd0);
      check("rst_fault", 32'(fault), 32'd0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;

    // addu
    op = 6'h00; func = 6'h21;
    cyc("addu_f", 3'd0, f(1,1,0,0,2'd0,0,2'd1,0,4'd0,2'd0,0));
    cyc("addu_d", 3'd1, f(0,0,0,0,2'd0,0,2'd1,0,4'd0,2'd0,0));
    cyc("addu_e", 3'd2, f(0,0,0,0,2'd0,0,2'd1,0,4'd0,2'd0,0));
    cyc("addu_w", 3'd4, f(0,0,0,0,2'd0,0,2'd1,1,4'd0,2'd0,0));

    // subu
    func = 6'h23;
    cyc("subu_f", 3'd0, f(1,1,0,0,2'd0,0,2'd1,0,4'd1,2'd0,0));
    cyc("subu_d", 3'd1, f(0,0,0,0,2'd0,0,2'd1,0,4'd1,2'd0,0));
    cyc("subu_e", 3'd2, f(0,0,0,0,2'd0,0,2'd1,0,4'd1,2'd0,0));
    cyc("subu_w", 3'd4, f(0,0,0,0,2'd0,0,2'd1,1,4'd1,2'd0,0));

    // ori, lui
    op = 6'h0D; func = 6'h00;
    cyc("ori_f", 3'd0, f(1,1,0,0,2'd0,1,2'd0,0,4'd2,2'd0,0));
    cyc("ori_d", 3'd1, f(0,0,0,0,2'd0,1,2'd0,0,4'd2,2'd0,0));
    cyc("ori_e", 3'd2, f(0,0,0,0,2'd0,1,2'd0,0,4'd2,2'd0,0));
    cyc("ori_w", 3'd4, f(0,0,0,0,2'd0,1,2'd0,1,4'd2,2'd0,0));
    op = 6'h0F;
    cyc("lui_f", 3'd0, f(1,1,0,0,2'd0,1,2'd0,0,4'd3,2'd0,0));
    cyc("lui_d", 3'd1, f(0,0,0,0,2'd0,1,2'd0,0,4'd3,2'd0,0));
    cyc("lui_e", 3'd2, f(0,0,0,0,2'd0,1,2'd0,0,4'd3,2'd0,0));
    cyc("lui_w", 3'd4, f(0,0,0,0,2'd0,1,2'd0,1,4'd3,2'd0,0));

    // lw with three wait cycles: 8 cycles total
    op = 6'h23;
    cyc("lw_f", 3'd0, LW_SEL | f(1,1,0,0,2'd0,0,2'd0,0,4'd0,2'd0,0));
    cyc("lw_d", 3'd1, LW_SEL);
    cyc("lw_e", 3'd2, LW_SEL);
    for (int i = 0; i < 3; i++) cyc("lw_wait", 3'd3, LW_SEL | f(0,0,1,0,2'd0,0,2'd0,0,4'd0,2'd0,0));
    mem_ready = 1'b1;
    cyc("lw_rdy", 3'd3, LW_SEL | f(0,0,1,0,2'd0,0,2'd0,0,4'd0,2'd0,0));
    mem_ready = 1'b0;
    cyc("lw_w", 3'd4, LW_SEL | f(0,0,0,0,2'd0,0,2'd0,1,4'd0,2'd0,0));

    // beq taken / not taken; FETCH always selects PC+4
    op = 6'h04; zero = 1'b1;
    cyc("beq1_f", 3'd0, f(1,1,0,0,2'd0,0,2'd0,0,4'd1,2'd0,1));
    cyc("beq1_d", 3'd1, BEQ_SEL);
    cyc("beq1_e", 3'd2, BEQ_SEL | f(0,1,0,0,2'd0,0,2'd0,0,4'd0,2'd0,0));
    zero = 1'b0;
    cyc("beq0_f", 3'd0, f(1,1,0,0,2'd0,0,2'd0,0,4'd1,2'd0,1));
    cyc("beq0_d", 3'd1, BEQ_SEL);
    cyc("beq0_e", 3'd2, BEQ_SEL);

    // j, jr, nop, jal
    op = 6'h02;
    cyc("j_f", 3'd0, f(1,1,0,0,2'd0,0,2'd0,0,4'd0,2'd0,0));
    cyc("j_d", 3'd1, f(0,1,0,0,2'd0,0,2'd0,0,4'd0,2'd2,0));
    op = 6'h00; func = 6'h08;
    cyc("jr_f", 3'd0, f(1,1,0,0,2'd0,0,2'd0,0,4'd0,2'd0,0));
    cyc("jr_d", 3'd1, f(0,1,0,0,2'd0,0,2'd0,0,4'd0,2'd3,0));
    func = 6'h00;
    cyc("nop_f", 3'd0, f(1,1,0,0,2'd0,0,2'd0,0,4'd0,2'd0,0));
    cyc("nop_d", 3'd1, f(0,0,0,0,2'd0,0,2'd0,0,4'd0,2'd0,0));
    op = 6'h03;
    cyc("jal_f", 3'd0, f(1,1,0,0,2'd2,0,2'd2,0,4'd0,2'd0,0));
    cyc("jal_d", 3'd1, f(0,1,0,0,2'd2,0,2'd2,1,4'd0,2'd2,0));

    // sw, ready arrives in the last allowed MEM cycle (index 14)
    op = 6'h2B;
    cyc("sw14_f", 3'd0, SW_SEL | f(1,1,0,0,2'd0,0,2'd0,0,4'd0,2'd0,0));
    cyc("sw14_d", 3'd1, SW_SEL);
    cyc("sw14_e", 3'd2, SW_SEL);
    for (int i = 0; i < 14; i++) cyc("sw14_wait", 3'd3, SW_SEL | f(0,0,0,1,2'd0,0,2'd0,0,4'd0,2'd0,0));
    mem_ready = 1'b1;
    cyc("sw14_rdy", 3'd3, SW_SEL | f(0,0,0,1,2'd0,0,2'd0,0,4'd0,2'd0,0));
    mem_ready = 1'b0;

    // sw, ready never arrives: 15 MEM cycles then FAULT
    cyc("swto_f", 3'd0, SW_SEL | f(1,1,0,0,2'd0,0,2'd0,0,4'd0,2'd0,0));
    cyc("swto_d", 3'd1, SW_SEL);
    cyc("swto_e", 3'd2, SW_SEL);
    for (int i = 0; i < 15; i++) cyc("swto_wait", 3'd3, SW_SEL | f(0,0,0,1,2'd0,0,2'd0,0,4'd0,2'd0,0));
    cyc("swto_fault", 3'd7, SW_SEL);
    mem_ready = 1'b1;
    cyc("swto_hold", 3'd7, SW_SEL);
    mem_ready = 1'b0;
    pulse_reset("swto_rst");

    // unsupported opcode
    op = 6'h3F;
    cyc("bad_f", 3'd0, f(1,1,0,0,2'd0,0,2'd0,0,4'd0,2'd0,0));
    cyc("bad_d", 3'd1, 17'd0);
    cyc("bad_fault", 3'd7, 17'd0);
    cyc("bad_hold", 3'd7, 17'd0);
    pulse_reset("bad_rst");

    // reset in the middle of a lw wait
    op = 6'h23;
    cyc("lwr_f", 3'd0, LW_SEL | f(1,1,0,0,2'd0,0,2'd0,0,4'd0,2'd0,0));
    cyc("lwr_d", 3'd1, LW_SEL);
    cyc("lwr_e", 3'd2, LW_SEL);
    cyc("lwr_m0", 3'd3, LW_SEL | f(0,0,1,0,2'd0,0,2'd0,0,4'd0,2'd0,0));
    pulse_reset("lwr_rst");
    cyc("lwr_f2", 3'd0, LW_SEL | f(1,1,0,0,2'd0,0,2'd0,0,4'd0,2'd0,0));
    cyc("lwr_d2", 3'd1, LW_SEL);
    cyc("lwr_e2", 3'd2, LW_SEL);
    mem_ready = 1'b1;
    cyc("lwr_m2", 3'd3, LW_SEL | f(0,0,1,0,2'd0,0,2'd0,0,4'd0,2'd0,0));
    mem_ready = 1'b0;
    cyc("lwr_w2", 3'd4, LW_SEL | f(0,0,0,0,2'd0,0,2'd0,1,4'd0,2'd0,0));
    op = 6'h00; func = 6'h00;
    cyc("end_f", 3'd0, f(1,1,0,0,2'd0,0,2'd0,0,4'd0,2'd0,0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
